ram_gather_reader: RTL and testbench

Read-side gather engine that sits directly downstream of the 8R1W replicated RAM and drives all eight of its read ports. On a start command it streams a contiguous address range out of the RAM, 8 words per cycle, into 256-bit beats on a valid/ready output. Backpressure is absorbed in a small skid buffer, so the RAM read ports are never stalled mid-read.

---
 rtl/ram_gather_reader_if.sv | 29 ++
 rtl/ram_gather_reader.sv | 232 +++++++++++++++++++++++
 tb/tb_ram_gather_reader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_gather_reader_if.sv
// Output beat stream of the RAM gather reader: 256-bit beats with a lane
// mask and end-of-command marker, valid/ready handshake.
//   valid/data/mask/last : master -> slave
//   ready                : slave -> master
interface ram_gather_reader_if #(
    parameter int DW = 32
);
    logic            valid;
    logic            ready;
    logic [8*DW-1:0] data;
    logic [7:0]      mask;
    logic            last;

    modport master (
        output valid,
        output data,
        output mask,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  mask,
        input  last,
        output ready
    );
endinterface

// File: rtl/ram_gather_reader.sv
// Gather engine driving all eight read ports of the replicated RAM; streams
// a contiguous word range out as 8-lane beats with a 2-entry skid FIFO.
// Ports: clk, rst (sync, active-low), start/base_addr/length command,
//   busy/done status, r1_addr..r8_addr RAM addresses, d1..d8 RAM data
//   (one cycle latency), out_if beat stream (master).
module ram_gather_reader #(
    parameter int BLOCKSIZE = 10,
    parameter int DW        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BLOCKSIZE:0]   base_addr,
    input  logic [BLOCKSIZE+1:0] length,
    output logic                 busy,
    output logic                 done,
    output logic [BLOCKSIZE:0]   r1_addr,
    output logic [BLOCKSIZE:0]   r2_addr,
    output logic [BLOCKSIZE:0]   r3_addr,
    output logic [BLOCKSIZE:0]   r4_addr,
    output logic [BLOCKSIZE:0]   r5_addr,
    output logic [BLOCKSIZE:0]   r6_addr,
    output logic [BLOCKSIZE:0]   r7_addr,
    output logic [BLOCKSIZE:0]   r8_addr,
    input  logic [DW-1:0]        d1,
    input  logic [DW-1:0]        d2,
    input  logic [DW-1:0]        d3,
    input  logic [DW-1:0]        d4,
    input  logic [DW-1:0]        d5,
    input  logic [DW-1:0]        d6,
    input  logic [DW-1:0]        d7,
    input  logic [DW-1:0]        d8,
    ram_gather_reader_if.master  out_if
);
    localparam int AW = BLOCKSIZE + 1;
    localparam int LW = BLOCKSIZE + 2;
    localparam int BW = LW - 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]   next_addr_q, next_addr_d;
    logic [BW-1:0]   beats_left_q, beats_left_d;
    logic [7:0]      last_mask_q, last_mask_d;
    logic [1:0]      credit_q, credit_d;
    logic [AW-1:0]   addr_q [8];
    logic [AW-1:0]   addr_d [8];

    // Beat whose addresses went out last cycle; its data is on d1..d8 now.
    logic            infl_q, infl_d;
    logic [7:0]      infl_mask_q, infl_mask_d;
    logic            infl_last_q, infl_last_d;

    logic [8*DW-1:0] fifo_data_q [2];
    logic [8*DW-1:0] fifo_data_d [2];
    logic [7:0]      fifo_mask_q [2];
    logic [7:0]      fifo_mask_d [2];
    logic            fifo_last_q [2];
    logic            fifo_last_d [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;

    logic [DW-1:0]   rdata [8];
    logic [8*DW-1:0] lane_data;
    logic [LW-1:0]   len_p7;
    logic            hs;
    logic            issue;

    assign rdata[0] = d1;
    assign rdata[1] = d2;
    assign rdata[2] = d3;
    assign rdata[3] = d4;
    assign rdata[4] = d5;
    assign rdata[5] = d6;
    assign rdata[6] = d7;
    assign rdata[7] = d8;

    // Addresses are driven straight from the next-state value so a beat's
    // addresses appear in the cycle it issues, and hold otherwise.
    assign r1_addr = addr_d[0];
    assign r2_addr = addr_d[1];
    assign r3_addr = addr_d[2];
    assign r4_addr = addr_d[3];
    assign r5_addr = addr_d[4];
    assign r6_addr = addr_d[5];
    assign r7_addr = addr_d[6];
    assign r8_addr = addr_d[7];

    assign out_if.valid = (count_q != 2'd0);
    assign out_if.data  = fifo_data_q[rd_ptr_q];
    assign out_if.mask  = fifo_mask_q[rd_ptr_q];
    assign out_if.last  = fifo_last_q[rd_ptr_q];

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FIN);

    assign hs     = out_if.valid && out_if.ready;
    // A handshake this cycle frees a slot, so issue may reuse it at once.
    assign issue  = (state_q == S_ISSUE) && ((credit_q != 2'd0) || hs);
    assign len_p7 = length + LW'(7);

    always_comb begin
        state_d      = state_q;
        next_addr_d  = next_addr_q;
        beats_left_d = beats_left_q;
        last_mask_d  = last_mask_q;
        credit_d     = credit_q + 2'(hs) - 2'(issue);
        addr_d       = addr_q;
        infl_d       = 1'b0;
        infl_mask_d  = infl_mask_q;
        infl_last_d  = infl_last_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    next_addr_d  = base_addr;
                    beats_left_d = len_p7[LW-1:3];
                    if (length[2:0] == 3'd0) begin
                        last_mask_d = 8'hFF;
                    end else begin
                        last_mask_d = ~(8'hFF << length[2:0]);
                    end
                    if (length == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    for (int k = 0; k < 8; k++) begin
                        addr_d[k] = next_addr_q + AW'(k);
                    end
                    next_addr_d  = next_addr_q + AW'(8);
                    beats_left_d = beats_left_q - BW'(1);
                    infl_d       = 1'b1;
                    infl_last_d  = (beats_left_q == BW'(1));
                    infl_mask_d  = infl_last_d ? last_mask_q : 8'hFF;
                    if (infl_last_d) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (credit_d == 2'd2) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        lane_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (infl_mask_q[k]) begin
                lane_data[DW*k +: DW] = rdata[k];
            end
        end
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_mask_d = fifo_mask_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + 2'(infl_q) - 2'(hs);
        if (infl_q) begin
            fifo_data_d[wr_ptr_q] = lane_data;
            fifo_mask_d[wr_ptr_q] = infl_mask_q;
            fifo_last_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (hs) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            next_addr_q  <= '0;
            beats_left_q <= '0;
            last_mask_q  <= '0;
            credit_q     <= 2'd2;
            infl_q       <= 1'b0;
            infl_mask_q  <= '0;
            infl_last_q  <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
            for (int k = 0; k < 8; k++) begin
                addr_q[k] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_mask_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            beats_left_q <= beats_left_d;
            last_mask_q  <= last_mask_d;
            credit_q     <= credit_d;
            infl_q       <= infl_d;
            infl_mask_q  <= infl_mask_d;
            infl_last_q  <= infl_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            fifo_data_q  <= fifo_data_d;
            fifo_mask_q  <= fifo_mask_d;
            fifo_last_q  <= fifo_last_d;
        end
    end
endmodule

// File: tb/tb_ram_gather_reader.sv
// Directed bench for ram_gather_reader: RAM model with mem[a]=3a, scoreboard
// of expected beats, timing/wrap/backpressure/reset scenarios.
module tb_ram_gather_reader;
    localparam int DW = 32;
    localparam int AW = 11;
    localparam int LW = 12;

    typedef struct {
        logic [8*DW-1:0] data;
        logic [7:0]      mask;
        logic            last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] ra [8];
    logic [DW-1:0] d [8];
    logic [DW-1:0] mem [2048];

    beat_t sb [$];
    int    total = 0;
    int    passed = 0;
    int    fails = 0;
    int    hs_cnt = 0;
    int    bp_hs = 0;
    int    iss_cnt = 0;
    bit    bp_mon = 1'b0;
    logic [AW-1:0] prev_r1 = '0;

    ram_gather_reader_if #(.DW(DW)) oif ();

    ram_gather_reader #(.BLOCKSIZE(10), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base_addr(base_addr), .length(length),
        .busy(busy), .done(done),
        .r1_addr(ra[0]), .r2_addr(ra[1]), .r3_addr(ra[2]), .r4_addr(ra[3]),
        .r5_addr(ra[4]), .r6_addr(ra[5]), .r7_addr(ra[6]), .r8_addr(ra[7]),
        .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]),
        .d5(d[4]), .d6(d[5]), .d7(d[6]), .d8(d[7]),
        .out_if(oif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            d[k] <= mem[ra[k]];
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input int b, input int l);
        int nb;
        nb = (l + 7) / 8;
        for (int bt = 0; bt < nb; bt++) begin
            beat_t e;
            e.data = '0;
            e.mask = '0;
            for (int k = 0; k < 8; k++) begin
                int idx;
                int a;
                idx = 8 * bt + k;
                a = (b + idx) % 2048;
                if (idx < l) begin
                    e.data[DW*k +: DW] = 32'(3 * a);
                    e.mask[k] = 1'b1;
                end
            end
            e.last = (bt == nb - 1);
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input int b, input int l);
        base_addr = AW'(b);
        length = LW'(l);
        start = 1'b1;
        push_cmd(b, l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n;
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        chk(tag, done, 1'b1);
        tick();
    endtask

    // Output monitor: scoreboard pop, stall stability, outstanding bound.
    initial begin
        beat_t prev;
        beat_t e;
        logic  stall_p;
        stall_p = 1'b0;
        prev = '{default: '0};
        forever begin
            @(negedge clk);
            if (rst) begin
                if (stall_p) begin
                    chk("stall_valid", oif.valid, 1'b1);
                    chk("stall_data", oif.data, prev.data);
                    chk("stall_mask", oif.mask, prev.mask);
                    chk("stall_last", oif.last, prev.last);
                end
                if (bp_mon) begin
                    if (busy && ra[0] != prev_r1) iss_cnt++;
                    prev_r1 = ra[0];
                end
                if (oif.valid && oif.ready) begin
                    hs_cnt++;
                    if (bp_mon) bp_hs++;
                    chk("sb_nonempty", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("beat_data", oif.data, e.data);
                        chk("beat_mask", oif.mask, e.mask);
                        chk("beat_last", oif.last, e.last);
                    end
                end
                if (bp_mon) begin
                    chk("outstanding_le2", (iss_cnt - bp_hs) <= 2, 1'b1);
                end
                stall_p = oif.valid && !oif.ready;
                prev.data = oif.data;
                prev.mask = oif.mask;
                prev.last = oif.last;
            end else begin
                stall_p = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 32'(3 * i);
        end
        oif.ready = 1'b1;

        // reset state
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", oif.valid, 1'b0);
        chk("rst_r1", ra[0], 0);
        chk("rst_r8", ra[7], 0);
        rst = 1'b1;
        tick();

        // single beat, cycle-exact timing
        do_start(0, 8);
        chk("c1_busy", busy, 1'b1);
        chk("c1_r1", ra[0], 0);
        chk("c1_r8", ra[7], 7);
        chk("c1_valid", oif.valid, 1'b0);
        tick();
        chk("c2_valid", oif.valid, 1'b0);
        tick();
        chk("c3_valid", oif.valid, 1'b1);
        chk("c3_done", done, 1'b0);
        tick();
        chk("c4_done", done, 1'b1);
        chk("c4_busy", busy, 1'b1);
        chk("c4_valid", oif.valid, 1'b0);
        tick();
        chk("c5_done", done, 1'b0);
        chk("c5_busy", busy, 1'b0);
        chk("t1_sb_empty", sb.size(), 0);

        // partial last beat
        do_start(100, 19);
        wait_done("t2_done", 40);
        chk("t2_sb_empty", sb.size(), 0);

        // address wrap
        do_start(2044, 8);
        chk("wrap_r1", ra[0], 2044);
        chk("wrap_r4", ra[3], 2047);
        chk("wrap_r5", ra[4], 0);
        chk("wrap_r8", ra[7], 3);
        wait_done("t3_done", 40);
        chk("t3_sb_empty", sb.size(), 0);

        // backpressure
        prev_r1 = ra[0];
        iss_cnt = 0;
        bp_hs = 0;
        bp_mon = 1'b1;
        do_start(300, 64);
        for (int i = 0; i < 400 && !done; i++) begin
            if (i >= 4 && i < 14) oif.ready = 1'b0;
            else oif.ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("bp_done", done, 1'b1);
        oif.ready = 1'b1;
        bp_mon = 1'b0;
        chk("bp_beats", bp_hs, 8);
        chk("bp_issues", iss_cnt, 8);
        chk("bp_sb_empty", sb.size(), 0);
        tick();

        // start while busy ignored
        do_start(0, 8);
        base_addr = AW'(500);
        length = LW'(16);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        wait_done("ign_done", 40);
        repeat (4) tick();
        chk("ign_busy", busy, 1'b0);
        chk("ign_valid", oif.valid, 1'b0);
        chk("ign_sb_empty", sb.size(), 0);

        // zero length
        do_start(0, 0);
        chk("z_busy", busy, 1'b1);
        chk("z_done", done, 1'b1);
        chk("z_valid", oif.valid, 1'b0);
        tick();
        chk("z2_busy", busy, 1'b0);
        chk("z2_done", done, 1'b0);
        chk("z2_valid", oif.valid, 1'b0);

        // reset during beat 3
        hs0 = hs_cnt;
        do_start(40, 64);
        repeat (5) tick();
        chk("pre_rst_beats", hs_cnt - hs0, 3);
        sb.delete();
        rst = 1'b0;
        tick();
        chk("mr_busy", busy, 1'b0);
        chk("mr_done", done, 1'b0);
        chk("mr_valid", oif.valid, 1'b0);
        chk("mr_data", oif.data, 0);
        chk("mr_mask", oif.mask, 0);
        chk("mr_last", oif.last, 1'b0);
        chk("mr_r1", ra[0], 0);
        chk("mr_r8", ra[7], 0);
        rst = 1'b1;
        repeat (6) tick();
        chk("mr_no_stale", oif.valid, 1'b0);
        do_start(5, 8);
        chk("mr2_r1", ra[0], 5);
        wait_done("mr2_done", 40);
        chk("mr2_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
